// File: rtl/fwd_scoreboard.sv
// ============================================================================
// Module   : fwd_scoreboard
// Brief    : Operand forwarding select, decode hazard stall and long-latency
//            operation scoreboard for the in-order integer pipeline.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_scoreboard #(
    parameter int NUM_SRC    = 2,
    parameter int NUM_STAGES = 2,
    parameter int MAX_LONG   = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [5*NUM_SRC-1:0]                de_rs,
    input  logic [4:0]                          de_rd,
    input  logic                                de_rd_wen,
    input  logic                                de_long,
    input  logic                                de_fire,
    input  logic [NUM_STAGES-1:0]               stg_valid,
    input  logic [5*NUM_STAGES-1:0]             stg_rd,
    input  logic [NUM_STAGES-1:0]               stg_late,
    input  logic                                lop_wb_valid,
    input  logic [4:0]                          lop_wb_rd,
    input  logic                                lop_kill,
    output logic                                fwd_stall,
    output logic [NUM_SRC*(NUM_STAGES+1)-1:0]   fwd_sel,
    output logic                                lop_full,
    output logic [31:0]                         lop_pending
);

    localparam int            CW      = $clog2(MAX_LONG + 1);
    localparam int            SW      = NUM_STAGES + 1;
    localparam logic [CW-1:0] c_max   = CW'(MAX_LONG);
    localparam logic [CW-1:0] c_one   = CW'(1);

    // Bit 0 is never set because issue requires a nonzero destination.
    logic [31:0]        r_pending;
    logic [CW-1:0]      r_count;
    logic [NUM_SRC-1:0] w_src_stall;
    logic               w_waw_stall;
    logic               w_cap_stall;
    logic               w_issue;
    logic               w_set;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [4:0]    w_rs;
            logic [SW-1:0] w_sel;
            logic          w_stall;
            logic          w_hit;

            assign w_rs = de_rs[5*gi +: 5];

            // Youngest matching stage wins; the scoreboard is only consulted
            // when no in-flight stage will produce the register.
            always_comb begin
                w_sel   = '0;
                w_stall = 1'b0;
                w_hit   = 1'b0;
                if (w_rs != 5'd0) begin
                    for (int s = 0; s < NUM_STAGES; s++) begin
                        if (!w_hit && stg_valid[s] && (stg_rd[5*s +: 5] == w_rs)) begin
                            w_hit    = 1'b1;
                            w_sel[s] = 1'b1;
                            w_stall  = stg_late[s];
                        end
                    end
                    if (!w_hit && r_pending[w_rs]) begin
                        if (lop_wb_valid && (lop_wb_rd == w_rs))
                            w_sel[NUM_STAGES] = 1'b1;
                        else
                            w_stall = 1'b1;
                    end
                end
            end

            assign fwd_sel[gi*SW +: SW] = w_sel;
            assign w_src_stall[gi]      = w_stall;
        end
    endgenerate

    assign w_waw_stall = de_rd_wen && (de_rd != 5'd0) && r_pending[de_rd] &&
                         !(lop_wb_valid && (lop_wb_rd == de_rd));
    assign w_cap_stall = de_long && (r_count == c_max) && !lop_wb_valid;
    assign fwd_stall   = (|w_src_stall) || w_waw_stall || w_cap_stall;

    assign w_issue = de_fire && de_long;
    assign w_set   = w_issue && de_rd_wen && (de_rd != 5'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
            r_count   <= '0;
        end else if (lop_kill) begin
            r_pending <= '0;
            r_count   <= '0;
        end else begin
            // Later assignment lets a same-register issue override the clear.
            if (lop_wb_valid)
                r_pending[lop_wb_rd] <= 1'b0;
            if (w_set)
                r_pending[de_rd] <= 1'b1;
            case ({w_issue, lop_wb_valid})
                2'b10:   r_count <= r_count + c_one;
                2'b01:   r_count <= r_count - c_one;
                default: r_count <= r_count;
            endcase
        end
    end

    assign lop_full    = (r_count == c_max);
    assign lop_pending = {r_pending[31:1], 1'b0};

endmodule

`default_nettype wire
